// File: rtl/res4_serial_pkg.sv
// res4_serial_pkg: shared definitions for the bit-serial subtractor.
//   RES_DEF_WIDTH : default operand width
//   state_e       : controller states (IDLE / RUN / DONE)
package res4_serial_pkg;

    localparam int RES_DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/res1.sv
// res1: combinational 1-bit full subtractor, d = a - b - b_in.
//   d     : difference bit
//   b_out : borrow out (1 when a < b + b_in)
//   a     : minuend bit
//   b     : subtrahend bit
//   b_in  : borrow in
module res1 (
    output logic d,
    output logic b_out,
    input  logic a,
    input  logic b,
    input  logic b_in
);

    assign d     = a ^ b ^ b_in;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/res4_serial.sv
// res4_serial: bit-serial subtractor D = A - B - b_in (mod 2^WIDTH), LSB first,
// one bit per clock through a single res1 cell.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request, accepted in IDLE or DONE
//   A, B, b_in : operands, captured on an accepted start
//   busy       : high while the serial run is in progress
//   done       : one-cycle pulse when D/b_out are updated
//   D, b_out   : registered difference and borrow-out
module res4_serial
    import res4_serial_pkg::*;
#(
    parameter int WIDTH = RES_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             b_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             b_out_q, b_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic cell_d, cell_bo;

    res1 u_res1 (
        .d     (cell_d),
        .b_out (cell_bo),
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .b_in  (br_q)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_sh_d  = d_sh_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        d_d     = d_q;
        b_out_d = b_out_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_sh_d  = A;
                    b_sh_d  = B;
                    br_d    = b_in;
                    cnt_d   = CW'(WIDTH - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                d_sh_d = {cell_d, d_sh_q[WIDTH-1:1]};
                br_d   = cell_bo;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    // Last bit: publish the shift register including this bit.
                    d_d     = d_sh_d;
                    b_out_d = cell_bo;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Flags follow the next state so they are registered alongside it.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            d_q     <= '0;
            b_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_sh_q  <= d_sh_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            d_q     <= d_d;
            b_out_q <= b_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign D     = d_q;
    assign b_out = b_out_q;

endmodule

// File: tb/tb_res4_serial.sv
// tb_res4_serial: directed self-checking bench for res4_serial (WIDTH = 4).
module tb_res4_serial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       b_in;
    logic       busy;
    logic       done;
    logic [3:0] D;
    logic       b_out;

    int checks;
    int errors;

    res4_serial #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .b_out (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sum4_v2(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y} + {4'b0, ci};
        return s[3:0];
    endfunction

    // Issue one operation; returns the result, cycles from accept edge to done,
    // and how many in-flight cycles had busy low.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                          output logic [3:0] dd, output logic bo,
                          output int lat, output int busy_bad);
        int n;
        @(posedge clk); #1;
        A = a; B = b; b_in = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        busy_bad = 0;
        while (!done && n < 20) begin
            if (!busy) busy_bad++;
            @(posedge clk); #1;
            n++;
        end
        lat = n;
        dd  = D;
        bo  = b_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; b_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, D, b_out} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b D=%b b_out=%b want all 0", busy, done, D, b_out);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_latency();
        logic [3:0] dd; logic bo; int lat, bb;
        run_op(4'b0000, 4'b0000, 1'b0, dd, bo, lat, bb);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL latency got %0d want 4", lat);
        end
        checks++;
        if (bb !== 0) begin
            errors++;
            $display("FAIL busy_during_run low for %0d cycles want 0", bb);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done got %b want 0", busy);
        end
        checks++;
        if ({bo, dd} !== 5'b0_0000) begin
            errors++;
            $display("FAIL zero_op got b_out=%b D=%b want 0 0000", bo, dd);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width done still %b want 0", done);
        end
    endtask

    task automatic test_vectors();
        logic [3:0] va [4] = '{4'b0000, 4'b0110, 4'b1111, 4'b1001};
        logic [3:0] vb [4] = '{4'b0001, 4'b0011, 4'b1111, 4'b0100};
        logic       vi [4] = '{1'b0,    1'b1,    1'b1,    1'b0};
        logic [3:0] ed [4] = '{4'b1111, 4'b0010, 4'b1111, 4'b0101};
        logic       eb [4] = '{1'b1,    1'b0,    1'b1,    1'b0};
        logic [3:0] dd; logic bo; int lat, bb;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vi[i], dd, bo, lat, bb);
            checks++;
            if ({bo, dd} !== {eb[i], ed[i]} || lat !== 4) begin
                errors++;
                $display("FAIL vector%0d got b_out=%b D=%b lat=%0d want %b %b lat=4",
                         i, bo, dd, lat, eb[i], ed[i]);
            end
        end
        // Outputs must hold between operations.
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({b_out, D} !== 5'b0_0101) begin
            errors++;
            $display("FAIL hold got b_out=%b D=%b want 0 0101", b_out, D);
        end
    endtask

    task automatic test_back_to_back();
        int ndone, bad_pos, bad_busy, bad_d;
        ndone = 0; bad_pos = 0; bad_busy = 0; bad_d = 0;
        @(posedge clk); #1;
        A = 4'b0101; B = 4'b0010; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        // Accept edge is c=0; subsequent loads at c=5,10; done visible at c%5==4.
        for (int c = 0; c < 15; c++) begin
            if (c % 5 == 2) A = 4'b1111;
            if (c % 5 == 3) A = 4'b0101;
            if (c % 5 == 4) begin
                if (!done) bad_pos++;
                else begin
                    ndone++;
                    if (D !== 4'b0011 || b_out !== 1'b0) bad_d++;
                end
                if (busy) bad_busy++;
            end else begin
                if (done) bad_pos++;
                if (!busy) bad_busy++;
            end
            if (c == 14) start = 1'b0;
            else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (ndone !== 3 || bad_pos !== 0) begin
            errors++;
            $display("FAIL b2b_done_timing got %0d dones %0d misplaced want 3 0", ndone, bad_pos);
        end
        checks++;
        if (bad_busy !== 0) begin
            errors++;
            $display("FAIL b2b_busy got %0d bad cycles want 0", bad_busy);
        end
        checks++;
        if (bad_d !== 0) begin
            errors++;
            $display("FAIL b2b_result got %0d wrong results want 0 (D=0011)", bad_d);
        end
    endtask

    task automatic test_reset_midrun();
        int seen;
        logic [3:0] dd; logic bo; int lat, bb;
        @(posedge clk); #1;
        A = 4'b1001; B = 4'b0100; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, D, b_out} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b D=%b b_out=%b want all 0", busy, done, D, b_out);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL no_done_after_reset got %0d active cycles want 0", seen);
        end
        run_op(4'b1001, 4'b0100, 1'b0, dd, bo, lat, bb);
        checks++;
        if ({bo, dd} !== 5'b0_0101 || lat !== 4) begin
            errors++;
            $display("FAIL post_reset_op got b_out=%b D=%b lat=%0d want 0 0101 lat=4", bo, dd, lat);
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] dd; logic bo; int lat, bb;
        logic [4:0] exp;
        int bad, bad_x;
        bad = 0; bad_x = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++) begin
                    run_op(4'(a), 4'(b), 1'(bi), dd, bo, lat, bb);
                    exp = 5'(a) - 5'(b) - 5'(bi);
                    if ({bo, dd} !== exp || lat !== 4) begin
                        bad++;
                        if (bad <= 5)
                            $display("FAIL sweep a=%0d b=%0d bi=%0d got b_out=%b D=%b want %b %b",
                                     a, b, bi, bo, dd, exp[4], exp[3:0]);
                    end
                    if (sum4_v2(dd, 4'(b), 1'(bi)) !== 4'(a)) bad_x++;
                end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL sweep_total got %0d bad vectors want 0", bad);
        end
        checks++;
        if (bad_x !== 0) begin
            errors++;
            $display("FAIL sum4_crosscheck got %0d bad vectors want 0", bad_x);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_reset_midrun();
        test_exhaustive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
